ddr_axi_slave: RTL and testbench
================================

DDR_AXI_SLAVE -- requirements
Module: ddr_axi_slave

Interface
REQ-001 Parameter MEM_WORDS, default 2048: depth of the internal 32-bit word store (power of two).
REQ-002 Parameter READ_LAT, default 3: cycles from AR handshake to first RVALID (legal 1..15).
REQ-003 ACLK  in  1  sole clock; all logic on rising edge; no second clock port.
REQ-004 ARESETn  in  1  reset; synchronous, active-low.
REQ-005 S0_AWADDR in 32 write burst byte address; S0_AWLEN in 4 beats-1; S0_AWVALID in 1; S0_AWREADY out 1.
REQ-006 S0_WDATA in 32; S0_WSTRB in 4 byte enables; S0_WLAST in 1; S0_WVALID in 1; S0_WREADY out 1.
REQ-007 S0_BRESP out 2; S0_BVALID out 1; S0_BREADY in 1.
REQ-008 S0_ARADDR in 32; S0_ARLEN in 4; S0_ARVALID in 1; S0_ARREADY out 1.
REQ-009 S0_RDATA out 32; S0_RRESP out 2; S0_RLAST out 1; S0_RVALID out 1; S0_RREADY in 1.

Function
REQ-010 Bursts are INCR only: beat k uses word index ADDR[31:2]+k; ADDR[1:0] ignored; length = LEN+1 (1..16).
REQ-011 Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE; S0_AWREADY=1 only in W_IDLE, S0_WREADY=1 only in W_DATA, S0_BVALID=1 only in W_RESP.
REQ-012 W_IDLE: on AWVALID&AWREADY latch address and length, go W_DATA next cycle.
REQ-013 W_DATA: each WVALID&WREADY writes byte lanes with WSTRB[i]=1, increments address, counts beat; after beat LEN+1 go W_RESP.
REQ-014 S0_WLAST not equal to (beat==LEN) on any beat sets the burst response to SLVERR (2'b10); the burst still ends after exactly LEN+1 beats.
REQ-015 W_RESP: S0_BRESP=OKAY (2'b00) unless an error was recorded; hold BVALID/BRESP until BREADY, then W_IDLE.
REQ-016 Read FSM R_IDLE -> R_LAT -> R_DATA -> R_IDLE; S0_ARREADY=1 only in R_IDLE.
REQ-017 AR handshake at edge N: S0_RVALID first high after edge N+READ_LAT with beat-0 data.
REQ-018 R_DATA: S0_RDATA/S0_RRESP/S0_RLAST held stable while RVALID&!RREADY; each RVALID&RREADY advances one beat; S0_RLAST=1 on beat ARLEN only; after last accepted beat, R_IDLE with RVALID=0.
REQ-019 Read and write FSMs run concurrently and independently; AWREADY/ARREADY never depend on the other channel.
REQ-020 Same-cycle write and read of one word: read returns pre-write contents.
REQ-021 Word index beyond MEM_WORDS-1 wraps modulo MEM_WORDS (when REQ-027 feature absent).
REQ-022 S0_RRESP=OKAY for every beat unless REQ-027 applies.
REQ-023 Uninitialised memory contents are undefined; the bench reads only written locations.

Reset
REQ-024 While ARESETn=0 at a rising edge: both FSMs to IDLE, beat counters and error flags cleared, in-flight bursts abandoned.
REQ-025 Reset values: S0_AWREADY, S0_WREADY, S0_BVALID, S0_ARREADY, S0_RVALID, S0_RLAST = 0; S0_BRESP, S0_RRESP = 2'b00; S0_RDATA = 0; AWREADY/ARREADY rise the first edge after release.
REQ-026 Memory contents are not altered by reset.

Configuration
REQ-027 Macro DDR_AXI_SLAVE_RANGE_CHECK_EN: when defined, any beat with word index >= MEM_WORDS is suppressed (no write; RDATA=0) and gives SLVERR (write: BRESP for the burst; read: RRESP for that beat); when undefined, indices wrap per REQ-021 and range never produces SLVERR.

Verification
REQ-028 Write 0x0000 LEN=3 data DEADBEEF,C0DECAFE,12345678,87654321 WSTRB=F -> 4 WREADY handshakes, BVALID with BRESP=00.
REQ-029 Write 0x1000 FADEDEAF,FEEDDEED,DEC0DED1,41594148, then read 0x0000 and 0x1000 LEN=3 -> exact data in order, RRESP=00, RLAST on 4th beat only, first RVALID READ_LAT cycles after AR.
REQ-030 Write 0x0010 word 0xFFFFFFFF, then single beat 0x11223344 WSTRB=0101 -> read returns 0xFF22FF44.
REQ-031 Read with RREADY low for 3 cycles mid-burst -> RDATA/RLAST stable, no beat lost; WLAST=1 on beat 1 of LEN=3 -> BRESP=10.
REQ-032 ARESETn low during W_DATA beat 2 -> next edge all READY/VALID 0; after release AWREADY=1 and new burst completes OKAY.
REQ-033 With DDR_AXI_SLAVE_RANGE_CHECK_EN, write/read at word index MEM_WORDS -> BRESP=10, RRESP=10, RDATA=0; without it, aliases index 0.

Source files
------------

// File: rtl/ddr_axi_slave.sv
// ddr_axi_slave: AXI-style INCR burst slave over an internal 32-bit word store.
// Define DDR_AXI_SLAVE_RANGE_CHECK_EN to turn out-of-range beats into SLVERR.
module ddr_axi_slave #(
  parameter int MEM_WORDS = 2048,
  parameter int READ_LAT  = 3
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic [31:0] S0_AWADDR,
  input  logic [3:0]  S0_AWLEN,
  input  logic        S0_AWVALID,
  output logic        S0_AWREADY,
  input  logic [31:0] S0_WDATA,
  input  logic [3:0]  S0_WSTRB,
  input  logic        S0_WLAST,
  input  logic        S0_WVALID,
  output logic        S0_WREADY,
  output logic [1:0]  S0_BRESP,
  output logic        S0_BVALID,
  input  logic        S0_BREADY,
  input  logic [31:0] S0_ARADDR,
  input  logic [3:0]  S0_ARLEN,
  input  logic        S0_ARVALID,
  output logic        S0_ARREADY,
  output logic [31:0] S0_RDATA,
  output logic [1:0]  S0_RRESP,
  output logic        S0_RLAST,
  output logic        S0_RVALID,
  input  logic        S0_RREADY
);
  localparam int IW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} r_state_e;

  logic [31:0] mem [MEM_WORDS];

  w_state_e    w_state_q, w_state_d;
  logic [29:0] waddr_q, waddr_d;
  logic [3:0]  wlen_q, wlen_d;
  logic [3:0]  wbeat_q, wbeat_d;
  logic        werr_q, werr_d;
  logic        rdy_en_q, rdy_en_d;
  logic        w_hs, w_oob, w_we;

  r_state_e    r_state_q, r_state_d;
  logic [29:0] raddr_q, raddr_d;
  logic [3:0]  rlen_q, rlen_d;
  logic [3:0]  rbeat_q, rbeat_d;
  logic [3:0]  lat_q, lat_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        r_oob;
  logic [31:0] fetch_data;
  logic [1:0]  fetch_resp;

  logic        unused_ok;
  assign unused_ok = ^{S0_AWADDR[1:0], S0_ARADDR[1:0],
                       waddr_q[29:IW], raddr_q[29:IW]};

`ifdef DDR_AXI_SLAVE_RANGE_CHECK_EN
  assign w_oob = 32'(waddr_q) >= 32'(MEM_WORDS);
  assign r_oob = 32'(raddr_q) >= 32'(MEM_WORDS);
`else
  assign w_oob = 1'b0;
  assign r_oob = 1'b0;
`endif

  // Ready outputs stay low through reset and rise one edge after release
  assign rdy_en_d   = 1'b1;
  assign S0_AWREADY = rdy_en_q && (w_state_q == W_IDLE);
  assign S0_WREADY  = (w_state_q == W_DATA);
  assign S0_BVALID  = (w_state_q == W_RESP);
  assign S0_BRESP   = (S0_BVALID && werr_q) ? 2'b10 : 2'b00;

  assign w_hs = S0_WVALID && S0_WREADY;
  assign w_we = ARESETn && w_hs && !w_oob;

  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wbeat_d   = wbeat_q;
    werr_d    = werr_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (S0_AWVALID && S0_AWREADY) begin
          w_state_d = W_DATA;
          waddr_d   = S0_AWADDR[31:2];
          wlen_d    = S0_AWLEN;
          wbeat_d   = 4'd0;
          werr_d    = 1'b0;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          waddr_d = waddr_q + 30'd1;
          wbeat_d = wbeat_q + 4'd1;
          if ((S0_WLAST != (wbeat_q == wlen_q)) || w_oob)
            werr_d = 1'b1;
          if (wbeat_q == wlen_q)
            w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S0_BREADY)
          w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (S0_WSTRB[i])
          mem[waddr_q[IW-1:0]][8*i +: 8] <= S0_WDATA[8*i +: 8];
      end
    end
  end

  // Asynchronous fetch: a same-edge write lands after this value is captured
  assign fetch_data = r_oob ? 32'd0 : mem[raddr_q[IW-1:0]];
  assign fetch_resp = r_oob ? 2'b10 : 2'b00;

  assign S0_ARREADY = rdy_en_q && (r_state_q == R_IDLE);
  assign S0_RVALID  = (r_state_q == R_DATA);
  assign S0_RLAST   = S0_RVALID && (rbeat_q == rlen_q);
  assign S0_RDATA   = rdata_q;
  assign S0_RRESP   = rresp_q;

  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rbeat_d   = rbeat_q;
    lat_d     = lat_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (S0_ARVALID && S0_ARREADY) begin
          r_state_d = R_LAT;
          raddr_d   = S0_ARADDR[31:2];
          rlen_d    = S0_ARLEN;
          rbeat_d   = 4'd0;
          lat_d     = 4'd0;
        end
      end
      R_LAT: begin
        if (lat_q == 4'(READ_LAT - 1)) begin
          r_state_d = R_DATA;
          rdata_d   = fetch_data;
          rresp_d   = fetch_resp;
          raddr_d   = raddr_q + 30'd1;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      R_DATA: begin
        if (S0_RREADY) begin
          if (rbeat_q == rlen_q) begin
            r_state_d = R_IDLE;
          end else begin
            rbeat_d = rbeat_q + 4'd1;
            rdata_d = fetch_data;
            rresp_d = fetch_resp;
            raddr_d = raddr_q + 30'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rdy_en_q  <= 1'b0;
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wbeat_q   <= '0;
      werr_q    <= 1'b0;
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      lat_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      rdy_en_q  <= rdy_en_d;
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      lat_q     <= lat_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_ddr_axi_slave.sv
// tb_ddr_axi_slave: directed bursts with a byte-merge memory model and
// read/response scoreboards.
module tb_ddr_axi_slave;
  localparam int MW = 2048;
  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] awaddr = '0;
  logic [3:0]  awlen = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [3:0]  arlen = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  ddr_axi_slave #(.MEM_WORDS(MW), .READ_LAT(RL)) dut (
    .ACLK(clk), .ARESETn(rstn),
    .S0_AWADDR(awaddr), .S0_AWLEN(awlen), .S0_AWVALID(awvalid),
    .S0_AWREADY(awready),
    .S0_WDATA(wdata), .S0_WSTRB(wstrb), .S0_WLAST(wlast),
    .S0_WVALID(wvalid), .S0_WREADY(wready),
    .S0_BRESP(bresp), .S0_BVALID(bvalid), .S0_BREADY(bready),
    .S0_ARADDR(araddr), .S0_ARLEN(arlen), .S0_ARVALID(arvalid),
    .S0_ARREADY(arready),
    .S0_RDATA(rdata), .S0_RRESP(rresp), .S0_RLAST(rlast),
    .S0_RVALID(rvalid), .S0_RREADY(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $fatal(1, "FAIL watchdog timeout");
  end

  int total = 0;
  int bad = 0;
  logic [31:0] model [int];
  logic [1:0]  bq [$];
  logic [34:0] rq [$];
  logic [31:0] wbuf [16];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_oob(input logic [31:0] a, input int k);
`ifdef DDR_AXI_SLAVE_RANGE_CHECK_EN
    return (int'(a[31:2]) + k) >= MW;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int idx_of(input logic [31:0] a, input int k);
    return (int'(a[31:2]) + k) % MW;
  endfunction

  task automatic model_wr(input int idx, input logic [31:0] d,
                          input logic [3:0] s);
    logic [31:0] m;
    m = model.exists(idx) ? model[idx] : 32'hx;
    for (int i = 0; i < 4; i++)
      if (s[i]) m[8*i +: 8] = d[8*i +: 8];
    model[idx] = m;
  endtask

  task automatic axi_write(input logic [31:0] a, input int len,
                           input logic [3:0] s, input int bad_beat,
                           input string tag);
    int n;
    bit err;
    err = 1'b0;
    @(negedge clk);
    awaddr = a; awlen = 4'(len); awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    chk({tag, " awready"}, awready, 1);
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      awvalid = 1'b0;
      wdata = wbuf[k]; wstrb = s; wvalid = 1'b1;
      wlast = (bad_beat >= 0) ? (k == bad_beat) : (k == len);
      if (wlast != (k == len)) err = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      chk({tag, " wready"}, wready, 1);
      if (is_oob(a, k)) err = 1'b1;
      else model_wr(idx_of(a, k), wbuf[k], s);
    end
    bq.push_back(err ? 2'b10 : 2'b00);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    chk({tag, " wready_after_last"}, wready, 0);
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    chk({tag, " bvalid"}, bvalid, 1);
    chk({tag, " bresp"}, bresp, bq.pop_front());
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk({tag, " bvalid_clear"}, bvalid, 0);
  endtask

  task automatic axi_read(input logic [31:0] a, input int len,
                          input bit stall, input string tag);
    int n, beat, st;
    logic [34:0] e;
    logic [31:0] hold_d;
    logic hold_l;
    hold_d = '0; hold_l = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if (is_oob(a, k)) rq.push_back({k == len, 2'b10, 32'd0});
      else rq.push_back({k == len, 2'b00, model[idx_of(a, k)]});
    end
    @(negedge clk);
    araddr = a; arlen = 4'(len); arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    chk({tag, " arready"}, arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 40) begin @(negedge clk); n++; end
    chk({tag, " first_rvalid_lat"}, 64'(n), 64'(RL));
    beat = 0; st = 0; n = 0;
    while (beat <= len && n < 200) begin
      if (rvalid) begin
        if (stall && beat == 1 && st < 3) begin
          rready = 1'b0;
          if (st == 0) begin
            hold_d = rdata; hold_l = rlast;
          end else begin
            chk({tag, " stall_rdata"}, rdata, hold_d);
            chk({tag, " stall_rlast"}, rlast, hold_l);
          end
          st++;
        end else begin
          rready = 1'b1;
          e = rq.pop_front();
          chk({tag, " rdata"}, rdata, e[31:0]);
          chk({tag, " rresp"}, rresp, e[33:32]);
          chk({tag, " rlast"}, rlast, e[34]);
          beat++;
        end
      end else begin
        rready = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    rready = 1'b0;
    chk({tag, " beats"}, 64'(beat), 64'(len + 1));
    chk({tag, " rvalid_idle"}, rvalid, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst awready", awready, 0);
    chk("rst wready", wready, 0);
    chk("rst bvalid", bvalid, 0);
    chk("rst arready", arready, 0);
    chk("rst rvalid", rvalid, 0);
    chk("rst rlast", rlast, 0);
    chk("rst bresp", bresp, 0);
    chk("rst rresp", rresp, 0);
    chk("rst rdata", rdata, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel awready", awready, 1);
    chk("rel arready", arready, 1);

    wbuf[0] = 32'hDEADBEEF; wbuf[1] = 32'hC0DECAFE;
    wbuf[2] = 32'h12345678; wbuf[3] = 32'h87654321;
    axi_write(32'h0000, 3, 4'hF, -1, "w0");
    wbuf[0] = 32'hFADEDEAF; wbuf[1] = 32'hFEEDDEED;
    wbuf[2] = 32'hDEC0DED1; wbuf[3] = 32'h41594148;
    axi_write(32'h1000, 3, 4'hF, -1, "w1000");
    axi_read(32'h0000, 3, 1'b0, "r0");
    axi_read(32'h1000, 3, 1'b0, "r1000");

    wbuf[0] = 32'hFFFFFFFF;
    axi_write(32'h0010, 0, 4'hF, -1, "wff");
    wbuf[0] = 32'h11223344;
    axi_write(32'h0010, 0, 4'b0101, -1, "wstrb");
    axi_read(32'h0010, 0, 1'b0, "rstrb");
    chk("strb model", model[4], 32'hFF22FF44);

    axi_read(32'h0000, 3, 1'b1, "rstall");

    wbuf[0] = 32'hA0A0A0A0; wbuf[1] = 32'hB1B1B1B1;
    wbuf[2] = 32'hC2C2C2C2; wbuf[3] = 32'hD3D3D3D3;
    axi_write(32'h0040, 3, 4'hF, 1, "wbadlast");
    axi_read(32'h0040, 3, 1'b0, "rbadlast");

    @(negedge clk);
    awaddr = 32'h0100; awlen = 4'd3; awvalid = 1'b1;
    chk("mid awready", awready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      awvalid = 1'b0;
      wdata = 32'h55000000 + k; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      chk("mid wready", wready, 1);
      if (k < 2) model_wr(32'h40 + k, wdata, 4'hF);
      else rstn = 1'b0;
    end
    @(negedge clk);
    wvalid = 1'b0;
    chk("mid awready", awready, 0);
    chk("mid wready0", wready, 0);
    chk("mid bvalid", bvalid, 0);
    chk("mid arready", arready, 0);
    chk("mid rvalid", rvalid, 0);
    chk("mid rdata", rdata, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("mid rel awready", awready, 1);
    wbuf[0] = 32'h01020304; wbuf[1] = 32'h05060708;
    wbuf[2] = 32'h090A0B0C; wbuf[3] = 32'h0D0E0F10;
    axi_write(32'h0100, 3, 4'hF, -1, "wpost");
    axi_read(32'h0100, 3, 1'b0, "rpost");

    wbuf[0] = 32'hA5A55A5A;
    axi_write(32'h2000, 0, 4'hF, -1, "wrange");
    axi_read(32'h2000, 0, 1'b0, "rrange");
    axi_read(32'h0000, 0, 1'b0, "ralias");

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
